// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: operand stage encodings
// and the default latency field width and unit latencies.
package hazard_pkg;

  localparam int LAT_W_DEF = 4;

  typedef enum logic [1:0] {
    STG_ID  = 2'd0,
    STG_EX  = 2'd1,
    STG_MEM = 2'd2
  } stage_e;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown: loads a latency on issue, decrements toward zero,
// holds during a pipeline freeze and flags when a result is still in flight.
module hazard_sb_entry #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             nz
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign nz = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register result countdowns drive RAW, WAW and
// shared-unit structural stalls, pipeline flushes and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int  NUM_REGS = 32,
  parameter int  LAT_W    = LAT_W_DEF,
  parameter int  PERF_W   = 32,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [IDX_W-1:0]  rs1_id,
  input  logic [IDX_W-1:0]  rs2_id,
  input  logic [IDX_W-1:0]  rd_id,
  input  logic              rs1_use,
  input  logic              rs2_use,
  input  logic [1:0]        rs1_stage,
  input  logic [1:0]        rs2_stage,
  input  logic              reg_write_id,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              is_multicycle_id,
  input  logic              branch_taken,
  input  logic              pipe_hold,
  input  logic              perf_clr,
  output logic              stall,
  output logic              flush_IFID,
  output logic              flush_IDEX,
  output logic [NUM_REGS-1:0] pending,
  output logic [PERF_W-1:0] stall_cycles
);

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] busy_cnt;
  logic             raw1_hz, raw2_hz, raw_hz, waw_hz, struct_hz;
  logic             issue, wr_en;

  // An operand consumed in stage S only needs the result S cycles from now,
  // so the countdown must exceed S to block it; reads see the pre-issue count.
  assign raw1_hz   = rs1_use && (rs1_id != '0) && (cnt[rs1_id] > LAT_W'(rs1_stage));
  assign raw2_hz   = rs2_use && (rs2_id != '0) && (cnt[rs2_id] > LAT_W'(rs2_stage));
  assign raw_hz    = raw1_hz | raw2_hz;
  assign waw_hz    = reg_write_id && (rd_id != '0) && (cnt[rd_id] > issue_lat);
  assign struct_hz = is_multicycle_id && (busy_cnt != '0);

  assign stall      = id_valid & (raw_hz | waw_hz | struct_hz);
  assign flush_IDEX = stall;
  assign flush_IFID = branch_taken & ~stall;

  assign issue = id_valid & ~stall & ~pipe_hold;
  assign wr_en = issue & reg_write_id & (issue_lat != '0);

  assign cnt[0]     = '0;
  assign pending[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_entry
      hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk      (clk),
        .rstn     (rstn),
        .hold     (pipe_hold),
        .load     (wr_en && (rd_id == IDX_W'(r))),
        .load_val (issue_lat),
        .cnt      (cnt[r]),
        .nz       (pending[r])
      );
    end
  endgenerate

  // The issuing cycle itself occupies the iterative unit, hence lat-1;
  // a zero latency never occupies it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_cnt <= '0;
    end else if (!pipe_hold) begin
      if (issue && is_multicycle_id) begin
        busy_cnt <= (issue_lat != '0) ? issue_lat - 1'b1 : '0;
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table of per-cycle ID instructions
// with hand-derived expectations, plus sequences for saturation, clear and reset.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NR = 32;
  localparam int LW = 4;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          id_valid;
  logic [4:0]    rs1_id, rs2_id, rd_id;
  logic          rs1_use, rs2_use;
  logic [1:0]    rs1_stage, rs2_stage;
  logic          reg_write_id;
  logic [LW-1:0] issue_lat;
  logic          is_multicycle_id, branch_taken, pipe_hold, perf_clr;
  logic          stall, flush_IFID, flush_IDEX;
  logic [NR-1:0] pending;
  logic [PW-1:0] stall_cycles;

  hazard_scoreboard #(.NUM_REGS(NR), .LAT_W(LW), .PERF_W(PW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .id_valid         (id_valid),
    .rs1_id           (rs1_id),
    .rs2_id           (rs2_id),
    .rd_id            (rd_id),
    .rs1_use          (rs1_use),
    .rs2_use          (rs2_use),
    .rs1_stage        (rs1_stage),
    .rs2_stage        (rs2_stage),
    .reg_write_id     (reg_write_id),
    .issue_lat        (issue_lat),
    .is_multicycle_id (is_multicycle_id),
    .branch_taken     (branch_taken),
    .pipe_hold        (pipe_hold),
    .perf_clr         (perf_clr),
    .stall            (stall),
    .flush_IFID       (flush_IFID),
    .flush_IDEX       (flush_IDEX),
    .pending          (pending),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs1; logic [1:0] s1; logic u1;
    logic [4:0] rs2; logic [1:0] s2; logic u2;
    logic [4:0] rd;  logic wr; logic [LW-1:0] lat; logic multi;
    logic       br;  logic hold;
    logic       e_stall; logic e_flush;
    logic [4:0] p_reg;   logic p_val;
  } vec_t;

  typedef struct {
    int         row;
    logic       e_stall; logic e_flush;
    logic [PW-1:0] e_sc;
    logic [4:0] p_reg;   logic p_val;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_sc  = 0;

  function automatic vec_t mk(input int valid, input int rs1, input int s1, input int u1,
                              input int rs2, input int s2, input int u2,
                              input int rd, input int wr, input int lat, input int multi,
                              input int br, input int hold, input int es, input int ef,
                              input int preg, input int pval);
    vec_t v;
    v.valid = 1'(valid); v.rs1 = 5'(rs1); v.s1 = 2'(s1); v.u1 = 1'(u1);
    v.rs2 = 5'(rs2); v.s2 = 2'(s2); v.u2 = 1'(u2);
    v.rd = 5'(rd); v.wr = 1'(wr); v.lat = LW'(lat); v.multi = 1'(multi);
    v.br = 1'(br); v.hold = 1'(hold); v.e_stall = 1'(es); v.e_flush = 1'(ef);
    v.p_reg = 5'(preg); v.p_val = 1'(pval);
    return v;
  endfunction

  function automatic logic [PW-1:0] sat(input int v);
    return (v >= (1 << PW) - 1) ? {PW{1'b1}} : PW'(v);
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.valid; rs1_id = v.rs1; rs1_stage = v.s1; rs1_use = v.u1;
    rs2_id = v.rs2; rs2_stage = v.s2; rs2_use = v.u2;
    rd_id = v.rd; reg_write_id = v.wr; issue_lat = v.lat; is_multicycle_id = v.multi;
    branch_taken = v.br; pipe_hold = v.hold;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam int ID  = int'(STG_ID);
  localparam int EX  = int'(STG_EX);
  localparam int MEM = int'(STG_MEM);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-register ALU / branch forwarding, then branch flush gating
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 5,1,LAT_ALU,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1, 5,EX,1, 0,0,0, 6,1,LAT_ALU,0, 0,0, 0,0, 5,1));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 5,1,LAT_ALU,0, 0,0, 0,0, 6,1));
    tbl.push_back(mk(1, 5,ID,1, 0,0,0, 0,0,0,0, 1,0, 1,0, 5,1));
    tbl.push_back(mk(1, 5,ID,1, 0,0,0, 0,0,0,0, 1,0, 0,1, 5,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    // Load-use for EX, ID and MEM consumers
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 7,1,LAT_LOAD,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1, 7,EX,1, 0,0,0, 11,1,1,0, 0,0, 1,0, 7,1));
    tbl.push_back(mk(1, 7,EX,1, 0,0,0, 11,1,1,0, 0,0, 0,0, 7,1));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 7,1,LAT_LOAD,0, 0,0, 0,0, 11,1));
    for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 7,ID,1, 0,0,0, 0,0,0,0, 0,0, 1,0, 7,1));
    tbl.push_back(mk(1, 7,ID,1, 0,0,0, 0,0,0,0, 0,0, 0,0, 7,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 7,1,LAT_LOAD,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1, 2,EX,1, 7,MEM,1, 0,0,0,0, 0,0, 0,0, 7,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    // Long-latency divide: WAW ordering, then shared-unit structural stall
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 8,1,6,1, 0,0, 0,0, 0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 0,0,0, 0,0,0, 8,1,1,0, 0,0, 1,0, 8,1));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 8,1,1,0, 0,0, 0,0, 8,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0, 8,1));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 8,1,6,1, 0,0, 0,0, 8,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 0,0,0, 0,0,0, 10,1,6,1, 0,0, 1,0, 8,1));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 10,1,6,1, 0,0, 0,0, 8,1));
    // Freeze during a load-use stall
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 9,1,LAT_LOAD,0, 0,0, 0,0, 0,0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 9,ID,1, 0,0,0, 0,0,0,0, 0,1, 1,0, 9,1));
    for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 9,ID,1, 0,0,0, 0,0,0,0, 0,0, 1,0, 9,1));
    tbl.push_back(mk(1, 9,ID,1, 0,0,0, 0,0,0,0, 0,0, 0,0, 9,0));

    perf_clr = 1'b0;
    rstn = 1'b0;
    drive(mk(1, 5,ID,1, 0,0,0, 5,1,1,0, 1,0, 0,0, 0,0));
    #12;
    check("reset stall", 32'(stall), 32'd0);
    check("reset flush_IFID", 32'(flush_IFID), 32'd1);
    check("reset pending", pending, 32'd0);
    check("reset stall_cycles", 32'(stall_cycles), 32'd0);
    next_cycle();
    rstn = 1'b1;
    drive(mk(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    next_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      drive(tbl[i]);
      e.row = i; e.e_stall = tbl[i].e_stall; e.e_flush = tbl[i].e_flush;
      e.e_sc = sat(exp_sc); e.p_reg = tbl[i].p_reg; e.p_val = tbl[i].p_val;
      exp_q.push_back(e);
      exp_sc += int'(tbl[i].e_stall);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("row%0d stall", e.row), 32'(stall), 32'(e.e_stall));
      check($sformatf("row%0d flush_IDEX", e.row), 32'(flush_IDEX), 32'(e.e_stall));
      check($sformatf("row%0d flush_IFID", e.row), 32'(flush_IFID), 32'(e.e_flush));
      check($sformatf("row%0d stall_cycles", e.row), 32'(stall_cycles), 32'(e.e_sc));
      check($sformatf("row%0d pending[%0d]", e.row, e.p_reg), 32'(pending[e.p_reg]), 32'(e.p_val));
      next_cycle();
    end

    // Saturation: a 15-cycle branch stall pushes the 5-bit counter past all-ones
    drive(mk(1, 0,0,0, 0,0,0, 5,1,15,0, 0,0, 0,0, 0,0));
    @(negedge clk);
    check("sat issue stall", 32'(stall), 32'd0);
    next_cycle();
    drive(mk(1, 5,ID,1, 0,0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check($sformatf("sat stall%0d", k), 32'(stall), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    check("sat release stall", 32'(stall), 32'd0);
    check("sat stall_cycles", 32'(stall_cycles), 32'h1f);
    next_cycle();

    // perf_clr during a stalled cycle clears instead of incrementing
    drive(mk(1, 0,0,0, 0,0,0, 5,1,15,0, 0,0, 0,0, 0,0));
    next_cycle();
    drive(mk(1, 5,ID,1, 0,0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    perf_clr = 1'b1;
    @(negedge clk);
    check("clr stall", 32'(stall), 32'd1);
    next_cycle();
    perf_clr = 1'b0;
    @(negedge clk);
    check("clr wins", 32'(stall_cycles), 32'd0);
    next_cycle();
    @(negedge clk);
    check("clr then count", 32'(stall_cycles), 32'd1);
    next_cycle();

    // Reset mid-countdown discards pending results
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    drive(mk(1, 0,0,0, 0,0,0, 5,1,4,0, 0,0, 0,0, 0,0));
    next_cycle();
    drive(mk(1, 5,ID,1, 0,0,0, 0,0,0,0, 1,0, 0,0, 0,0));
    @(negedge clk);
    check("mid pending[5]", 32'(pending[5]), 32'd1);
    check("mid stall", 32'(stall), 32'd1);
    check("mid flush_IFID", 32'(flush_IFID), 32'd0);
    rstn = 1'b0;
    #1;
    check("async pending", pending, 32'd0);
    check("async stall", 32'(stall), 32'd0);
    check("async flush_IFID", 32'(flush_IFID), 32'd1);
    check("async stall_cycles", 32'(stall_cycles), 32'd0);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check("post-reset stall", 32'(stall), 32'd0);
    check("post-reset pending", pending, 32'd0);
    next_cycle();
    drive(mk(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    @(negedge clk);
    check("post-reset stall_cycles", 32'(stall_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
